bk_sector_ctrl: RTL and testbench

- Parametrised multi-channel backup-RAM save/load sequencer.
- Streams N cartridge RAM regions (BSRAM, coprocessor RAM, RTC, …) to or from one mounted save image, sector by sector, over the hps_io sd_* handshake.
- Channels are packed back to back in the image.
- Sits in emu beside hps_io. Drives sd_lba/sd_rd/sd_wr and tells the channel RAMs which channel and sector the buffer port is serving.

---
 rtl/bk_pkg.sv | 20 ++
 rtl/bk_chan_map.sv | 56 +++++
 rtl/bk_sector_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_bk_sector_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bk_pkg.sv
// Shared types for the backup-RAM sector sequencer.
package bk_pkg;

    localparam int MAX_CHANNELS = 4;

    typedef enum logic [2:0] {
        IDLE,
        SEEK,
        ISSUE,
        WAIT_ACK,
        WAIT_END,
        FINISH
    } bk_state_t;

    typedef enum logic {
        BK_LOAD,
        BK_SAVE
    } bk_dir_t;

endpackage

// File: rtl/bk_chan_map.sv
// Per-channel sector count and image base, captured from MASK when a
// transfer starts so later MASK changes cannot disturb it.
module bk_chan_map import bk_pkg::*; #(
    parameter int CHANNELS    = 2,
    parameter int MASK_W      = 24,
    parameter int SECTOR_BITS = 9,
    localparam int CW         = MASK_W - SECTOR_BITS
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         load,
    input  logic [CHANNELS*MASK_W-1:0]   mask,
    input  logic [2:0]                   sel,
    output logic [CW:0]                  cnt,
    output logic [31:0]                  base
);

    logic [MAX_CHANNELS-1:0][CW:0]   cnt_nxt;
    logic [MAX_CHANNELS-1:0][31:0]   base_nxt;
    logic [MAX_CHANNELS-1:0][CW:0]   cnt_r;
    logic [MAX_CHANNELS-1:0][31:0]   base_r;

    // Absent channels (mask 0, or beyond CHANNELS) get zero sectors, and
    // each base is the running sum of the counts before it.
    for (genvar c = 0; c < MAX_CHANNELS; c++) begin : g_ch
        if (c < CHANNELS) begin : g_live
            logic [MASK_W-1:0] m;
            assign m          = mask[c*MASK_W +: MASK_W];
            assign cnt_nxt[c] = (|m) ? ({1'b0, m[MASK_W-1:SECTOR_BITS]} + {{CW{1'b0}}, 1'b1})
                                     : '0;
        end else begin : g_absent
            assign cnt_nxt[c] = '0;
        end
        if (c == 0) begin : g_b0
            assign base_nxt[c] = '0;
        end else begin : g_bn
            assign base_nxt[c] = base_nxt[c-1] + {{(31-CW){1'b0}}, cnt_nxt[c-1]};
        end
    end

    // Capture the geometry at trigger time.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_r  <= '0;
            base_r <= '0;
        end else if (load) begin
            cnt_r  <= cnt_nxt;
            base_r <= base_nxt;
        end
    end

    // Index 4..7 only appears after the last channel; report it as empty.
    assign cnt  = sel[2] ? '0 : cnt_r[sel[1:0]];
    assign base = sel[2] ? '0 : base_r[sel[1:0]];

endmodule

// File: rtl/bk_sector_ctrl.sv
// Multi-channel backup-RAM save/load sequencer driving the hps_io sd_*
// sector handshake. Optional autosave on OSD open: define BK_AUTOSAVE_EN.
module bk_sector_ctrl import bk_pkg::*; #(
    parameter int          CHANNELS    = 2,
    parameter int          MASK_W      = 24,
    parameter int          SECTOR_BITS = 9,
    parameter logic [23:0] TIMEOUT     = 24'd10000000,
    localparam int         CW          = MASK_W - SECTOR_BITS
) (
    input  logic                         CLK,
    input  logic                         RESET_N,
    input  logic                         DL_ACTIVE,
    input  logic                         IMG_MOUNTED,
    input  logic                         IMG_VALID,
    input  logic [CHANNELS*MASK_W-1:0]   MASK,
    input  logic                         LOAD_REQ,
    input  logic                         SAVE_REQ,
    input  logic                         SD_ACK,
`ifdef BK_AUTOSAVE_EN
    input  logic                         DIRTY,
    input  logic                         OSD_STATUS,
`endif
    output logic [31:0]                  SD_LBA,
    output logic                         SD_RD,
    output logic                         SD_WR,
    output logic [1:0]                   CH_SEL,
    output logic [CW-1:0]                CH_SECTOR,
    output logic                         ENA,
    output logic                         LOADING,
    output logic                         BUSY,
    output logic                         DONE,
    output logic                         ERR
);

    bk_state_t     state;
    bk_dir_t       dir;
    bk_dir_t       trig_dir;
    logic          trig;
    logic [2:0]    ch_idx;
    logic [23:0]   timer;
    logic          timed_out;
    logic          ack_q, load_q, save_q, dl_q;
    logic          ack_rise, ack_fall, load_rise, save_rise, dl_rise, dl_fall;
    logic [CW:0]   cnt;
    logic [31:0]   base;
    logic          last_sector;

    assign ack_rise  = SD_ACK & ~ack_q;
    assign ack_fall  = ~SD_ACK & ack_q;
    assign load_rise = LOAD_REQ & ~load_q;
    assign save_rise = SAVE_REQ & ~save_q;
    assign dl_rise   = DL_ACTIVE & ~dl_q;
    assign dl_fall   = ~DL_ACTIVE & dl_q;

    assign timed_out   = (timer >= TIMEOUT - 24'd1);
    assign last_sector = ({1'b0, CH_SECTOR} == cnt - {{CW{1'b0}}, 1'b1});

    assign CH_SEL = ch_idx[1:0];
    assign SD_LBA = base + {{(32-CW){1'b0}}, CH_SECTOR};

    bk_chan_map #(
        .CHANNELS   (CHANNELS),
        .MASK_W     (MASK_W),
        .SECTOR_BITS(SECTOR_BITS)
    ) u_map (
        .clk     (CLK),
        .reset_n (RESET_N),
        .load    (trig),
        .mask    (MASK),
        .sel     (ch_idx),
        .cnt     (cnt),
        .base    (base)
    );

`ifdef BK_AUTOSAVE_EN
    logic osd_q, dirty, auto_start;
    logic osd_rise;
    assign osd_rise = OSD_STATUS & ~osd_q;

    // Dirty flag: cleared as the autosave starts, re-armed by any later write.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            osd_q <= 1'b0;
            dirty <= 1'b0;
        end else begin
            osd_q <= OSD_STATUS;
            if (auto_start) dirty <= 1'b0;
            if (DIRTY)      dirty <= 1'b1;
        end
    end
`endif

    // Edge-detect history; edges that arrive while busy are simply lost.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            ack_q  <= 1'b0;
            load_q <= 1'b0;
            save_q <= 1'b0;
            dl_q   <= 1'b0;
        end else begin
            ack_q  <= SD_ACK;
            load_q <= LOAD_REQ;
            save_q <= SAVE_REQ;
            dl_q   <= DL_ACTIVE;
        end
    end

    // Start decode: only from IDLE with a usable image; load beats save.
    always_comb begin
        trig     = 1'b0;
        trig_dir = BK_LOAD;
`ifdef BK_AUTOSAVE_EN
        auto_start = 1'b0;
`endif
        if (state == IDLE && ENA && !dl_rise) begin
            if (load_rise || dl_fall) begin
                trig = 1'b1;
            end else if (save_rise) begin
                trig     = 1'b1;
                trig_dir = BK_SAVE;
            end
`ifdef BK_AUTOSAVE_EN
            else if (osd_rise && dirty) begin
                trig       = 1'b1;
                trig_dir   = BK_SAVE;
                auto_start = 1'b1;
            end
`endif
        end
    end

    // Sequencer: walk channels and sectors, one sd handshake per sector.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state     <= IDLE;
            dir       <= BK_LOAD;
            ch_idx    <= '0;
            CH_SECTOR <= '0;
            timer     <= '0;
            SD_RD     <= 1'b0;
            SD_WR     <= 1'b0;
            ENA       <= 1'b0;
            LOADING   <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            DONE <= 1'b0;
            if (dl_rise) ENA <= 1'b0;
            if (DL_ACTIVE && IMG_MOUNTED && IMG_VALID) ENA <= |MASK;

            if (state != IDLE && dl_rise) begin
                // A new ROM download invalidates everything; ERR untouched.
                state   <= IDLE;
                SD_RD   <= 1'b0;
                SD_WR   <= 1'b0;
                BUSY    <= 1'b0;
                LOADING <= 1'b0;
            end else if ((state == WAIT_ACK || state == WAIT_END) && timed_out) begin
                state   <= IDLE;
                ERR     <= 1'b1;
                SD_RD   <= 1'b0;
                SD_WR   <= 1'b0;
                BUSY    <= 1'b0;
                LOADING <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (trig) begin
                        dir       <= trig_dir;
                        ERR       <= 1'b0;
                        ch_idx    <= '0;
                        CH_SECTOR <= '0;
                        BUSY      <= 1'b1;
                        LOADING   <= (trig_dir == BK_LOAD);
                        state     <= SEEK;
                    end
                    SEEK: begin
                        if (ch_idx >= 3'(CHANNELS)) state  <= FINISH;
                        else if (cnt == '0)         ch_idx <= ch_idx + 3'd1;
                        else                        state  <= ISSUE;
                    end
                    ISSUE: begin
                        SD_RD <= (dir == BK_LOAD);
                        SD_WR <= (dir == BK_SAVE);
                        timer <= '0;
                        state <= WAIT_ACK;
                    end
                    WAIT_ACK: begin
                        timer <= timer + 24'd1;
                        if (ack_rise) begin
                            SD_RD <= 1'b0;
                            SD_WR <= 1'b0;
                            state <= WAIT_END;
                        end
                    end
                    WAIT_END: begin
                        timer <= timer + 24'd1;
                        if (ack_fall) begin
                            if (last_sector) begin
                                ch_idx    <= ch_idx + 3'd1;
                                CH_SECTOR <= '0;
                                state     <= SEEK;
                            end else begin
                                CH_SECTOR <= CH_SECTOR + CW'(1);
                                state     <= ISSUE;
                            end
                        end
                    end
                    FINISH: begin
                        DONE    <= 1'b1;
                        BUSY    <= 1'b0;
                        LOADING <= 1'b0;
                        state   <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bk_sector_ctrl.sv
// Directed bench for bk_sector_ctrl with an sd_ack responder and event log.
module tb_bk_sector_ctrl;

    localparam int CH = 2;
    localparam int MW = 24;
    localparam int SB = 9;
    localparam int CW = MW - SB;

    logic CLK = 1'b0, RESET_N = 1'b0, DL_ACTIVE = 1'b0, IMG_MOUNTED = 1'b0, IMG_VALID = 1'b0;
    logic LOAD_REQ = 1'b0, SAVE_REQ = 1'b0, SD_ACK = 1'b0;
    logic [CH*MW-1:0] MASK = '0;
    logic [31:0]   SD_LBA;
    logic          SD_RD, SD_WR, ENA, LOADING, BUSY, DONE, ERR;
    logic [1:0]    CH_SEL;
    logic [CW-1:0] CH_SECTOR;

    int checks = 0, failures = 0;
    bit ack_en = 1'b1;
    int log_lba[$];
    int log_sel[$];
    bit log_rd[$];
    int done_cnt = 0, both_cnt = 0, gap_cnt = 0, rd_cnt = 0, wr_cnt = 0;

    bk_sector_ctrl #(.CHANNELS(CH), .MASK_W(MW), .SECTOR_BITS(SB), .TIMEOUT(24'd100)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .DL_ACTIVE(DL_ACTIVE), .IMG_MOUNTED(IMG_MOUNTED),
        .IMG_VALID(IMG_VALID), .MASK(MASK), .LOAD_REQ(LOAD_REQ), .SAVE_REQ(SAVE_REQ),
        .SD_ACK(SD_ACK),
`ifdef BK_AUTOSAVE_EN
        .DIRTY(1'b0), .OSD_STATUS(1'b0),
`endif
        .SD_LBA(SD_LBA), .SD_RD(SD_RD), .SD_WR(SD_WR), .CH_SEL(CH_SEL),
        .CH_SECTOR(CH_SECTOR), .ENA(ENA), .LOADING(LOADING), .BUSY(BUSY),
        .DONE(DONE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    // hps_io stand-in: log each request, then a one-cycle ack pulse
    initial forever begin
        @(negedge CLK);
        if (ack_en && (SD_RD || SD_WR)) begin
            log_lba.push_back(int'(SD_LBA));
            log_sel.push_back(int'(CH_SEL));
            log_rd.push_back(SD_RD);
            @(negedge CLK); SD_ACK = 1'b1;
            @(negedge CLK); SD_ACK = 1'b0;
        end
    end

    // Running event counters; tests compare before/after snapshots
    always @(negedge CLK) begin
        if (DONE) done_cnt++;
        if (SD_RD && SD_WR) both_cnt++;
        if (SD_RD) rd_cnt++;
        if (SD_WR) wr_cnt++;
        if (BUSY && !LOADING) gap_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            if (DONE) begin ok = 1'b1; break; end
        end
        @(negedge CLK);
    endtask

    // Download + mount: arms ENA, the download's falling edge auto-loads
    task automatic enable_image(input logic [23:0] m0, input logic [23:0] m1);
        bit ok;
        MASK = {m1, m0}; IMG_VALID = 1'b1; DL_ACTIVE = 1'b1;
        cyc(1); IMG_MOUNTED = 1'b1;
        cyc(1); IMG_MOUNTED = 1'b0; DL_ACTIVE = 1'b0;
        wait_done(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL enable_autoload_done got=0 exp=1"); end
        cyc(3);
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        cyc(3);
        checks++;
        if ({SD_LBA, SD_RD, SD_WR, CH_SEL, CH_SECTOR, ENA, LOADING, BUSY, DONE, ERR} !== '0) begin
            failures++; $display("FAIL reset_outputs got=%0h exp=0",
                {SD_LBA, SD_RD, SD_WR, CH_SEL, CH_SECTOR, ENA, LOADING, BUSY, DONE, ERR});
        end
        RESET_N = 1'b1;
        cyc(2);
        checks++;
        if ({ENA, BUSY, SD_RD, SD_WR} !== 4'b0) begin
            failures++; $display("FAIL post_reset_idle got=%b exp=0000", {ENA, BUSY, SD_RD, SD_WR});
        end
    endtask

    task automatic test_load16();
        int n0, d0, g0, bad;
        bit ok;
        enable_image(24'h1FFF, 24'h0);
        n0 = log_lba.size(); d0 = done_cnt; g0 = gap_cnt;
        LOAD_REQ = 1'b1;
        cyc(2);
        checks++;
        if ({BUSY, LOADING} !== 2'b11) begin
            failures++; $display("FAIL load16_busy got=%b exp=11", {BUSY, LOADING});
        end
        LOAD_REQ = 1'b0;
        wait_done(ok);
        cyc(10);
        checks++;
        if (!ok || log_lba.size() - n0 != 16) begin
            failures++; $display("FAIL load16_count got=%0d exp=16", log_lba.size() - n0);
        end else begin
            bad = 0;
            for (int i = 0; i < 16; i++)
                if (log_lba[n0+i] != i || log_sel[n0+i] != 0 || log_rd[n0+i] != 1'b1) bad++;
            checks++;
            if (bad != 0) begin failures++; $display("FAIL load16_lba_seq got=%0d_bad exp=0", bad); end
        end
        checks++;
        if (done_cnt - d0 != 1) begin failures++; $display("FAIL load16_done got=%0d exp=1", done_cnt - d0); end
        checks++;
        if (gap_cnt - g0 != 0) begin failures++; $display("FAIL load16_loading_hold got=%0d exp=0", gap_cnt - g0); end
        checks++;
        if ({BUSY, LOADING} !== 2'b00) begin
            failures++; $display("FAIL load16_end_idle got=%b exp=00", {BUSY, LOADING});
        end
    endtask

    task automatic test_save_two_ch();
        int n0, r0, bad;
        int exp_sel[6] = '{0, 0, 0, 0, 1, 1};
        bit ok;
        enable_image(24'h7FF, 24'h3FF);
        n0 = log_lba.size(); r0 = rd_cnt;
        SAVE_REQ = 1'b1;
        cyc(2);
        SAVE_REQ = 1'b0;
        wait_done(ok);
        checks++;
        if (!ok || log_lba.size() - n0 != 6) begin
            failures++; $display("FAIL save_count got=%0d exp=6", log_lba.size() - n0);
        end else begin
            bad = 0;
            for (int i = 0; i < 6; i++)
                if (log_lba[n0+i] != i || log_sel[n0+i] != exp_sel[i] || log_rd[n0+i] != 1'b0) bad++;
            checks++;
            if (bad != 0) begin failures++; $display("FAIL save_lba_sel_seq got=%0d_bad exp=0", bad); end
        end
        checks++;
        if (rd_cnt - r0 != 0) begin failures++; $display("FAIL save_no_rd got=%0d exp=0", rd_cnt - r0); end
    endtask

    task automatic test_dl_autoload();
        int n0;
        bit ok;
        n0 = log_lba.size();
        MASK = {24'h1FF, 24'h0}; DL_ACTIVE = 1'b1;
        cyc(1); IMG_MOUNTED = 1'b1;
        cyc(1); IMG_MOUNTED = 1'b0; DL_ACTIVE = 1'b0;
        wait_done(ok);
        checks++;
        if (!ok || log_lba.size() - n0 != 1) begin
            failures++; $display("FAIL autoload_count got=%0d exp=1", log_lba.size() - n0);
        end else begin
            checks++;
            if (log_lba[n0] != 0 || log_sel[n0] != 1 || log_rd[n0] != 1'b1) begin
                failures++; $display("FAIL autoload_skip_ch0 got=lba%0d_sel%0d_rd%0d exp=lba0_sel1_rd1",
                                     log_lba[n0], log_sel[n0], log_rd[n0]);
            end
        end
        checks++;
        if (ENA !== 1'b1) begin failures++; $display("FAIL autoload_ena got=%b exp=1", ENA); end
    endtask

    task automatic test_both_req();
        int n0, w0, d0;
        bit ok;
        enable_image(24'h7FF, 24'h3FF);
        n0 = log_lba.size(); w0 = wr_cnt; d0 = done_cnt;
        LOAD_REQ = 1'b1; SAVE_REQ = 1'b1;
        cyc(2); SAVE_REQ = 1'b0;
        cyc(3); SAVE_REQ = 1'b1;
        cyc(1);
        checks++;
        if (BUSY !== 1'b1) begin failures++; $display("FAIL both_mid_busy got=%b exp=1", BUSY); end
        cyc(1); LOAD_REQ = 1'b0; SAVE_REQ = 1'b0;
        wait_done(ok);
        cyc(30);
        checks++;
        if (!ok || log_lba.size() - n0 != 6) begin
            failures++; $display("FAIL both_load_count got=%0d exp=6", log_lba.size() - n0);
        end
        checks++;
        if (wr_cnt - w0 != 0) begin failures++; $display("FAIL both_no_save got=%0d exp=0", wr_cnt - w0); end
        checks++;
        if (done_cnt - d0 != 1 || BUSY !== 1'b0) begin
            failures++; $display("FAIL both_single_done got=%0d_busy%b exp=1_busy0", done_cnt - d0, BUSY);
        end
        checks++;
        if (both_cnt != 0) begin failures++; $display("FAIL rd_wr_exclusive got=%0d exp=0", both_cnt); end
    endtask

    task automatic test_timeout();
        int d0, hi;
        bit seen;
        ack_en = 1'b0;
        d0 = done_cnt; hi = 0; seen = 1'b0;
        LOAD_REQ = 1'b1;
        cyc(1); LOAD_REQ = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            if (SD_RD) hi++;
            if (ERR) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL timeout_err got=0 exp=1"); end
        checks++;
        if (hi != 100) begin failures++; $display("FAIL timeout_cycles got=%0d exp=100", hi); end
        checks++;
        if ({BUSY, LOADING, SD_RD} !== 3'b000) begin
            failures++; $display("FAIL timeout_idle got=%b exp=000", {BUSY, LOADING, SD_RD});
        end
        cyc(20);
        checks++;
        if (ERR !== 1'b1 || done_cnt - d0 != 0) begin
            failures++; $display("FAIL timeout_sticky_nodone got=err%b_done%0d exp=err1_done0", ERR, done_cnt - d0);
        end
        ack_en = 1'b1;
        LOAD_REQ = 1'b1;
        cyc(1);
        checks++;
        if ({ERR, BUSY} !== 2'b01) begin
            failures++; $display("FAIL timeout_err_clear got=%b exp=01", {ERR, BUSY});
        end
        LOAD_REQ = 1'b0;
        wait_done(seen);
        checks++;
        if (!seen) begin failures++; $display("FAIL timeout_reload_done got=0 exp=1"); end
    endtask

    task automatic test_dl_abort();
        int d0, n1;
        bit found;
        enable_image(24'hFFF, 24'h0);
        d0 = done_cnt; found = 1'b0;
        LOAD_REQ = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge CLK);
            if (SD_RD && CH_SECTOR == 3) begin found = 1'b1; break; end
        end
        LOAD_REQ = 1'b0;
        DL_ACTIVE = 1'b1;
        cyc(1);
        checks++;
        if (!found || {SD_RD, ENA, BUSY, LOADING} !== 4'b0000) begin
            failures++; $display("FAIL abort_state got=found%b_%b exp=found1_0000",
                                 found, {SD_RD, ENA, BUSY, LOADING});
        end
        cyc(5);
        n1 = log_lba.size();
        LOAD_REQ = 1'b1;
        cyc(20);
        checks++;
        if (BUSY !== 1'b0 || log_lba.size() != n1 || done_cnt - d0 != 0 || ERR !== 1'b0) begin
            failures++; $display("FAIL abort_load_ignored got=busy%b_req%0d_done%0d_err%b exp=busy0_req0_done0_err0",
                                 BUSY, log_lba.size() - n1, done_cnt - d0, ERR);
        end
        LOAD_REQ = 1'b0; DL_ACTIVE = 1'b0;
        cyc(10);
        checks++;
        if (BUSY !== 1'b0 || log_lba.size() != n1) begin
            failures++; $display("FAIL abort_dl_fall_no_load got=busy%b_req%0d exp=busy0_req0",
                                 BUSY, log_lba.size() - n1);
        end
    endtask

    initial begin
        test_reset();
        test_load16();
        test_save_two_ch();
        test_dl_autoload();
        test_both_req();
        test_timeout();
        test_dl_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
